timx_pwm_gen: RTL and testbench

Parametrised multi-channel PWM generator for the advanced timer family. It provides:
- a prescaled counter with edge-aligned up, edge-aligned down and center-aligned modes;
- NUM_CH compare channels with shadow (preload) registers;
- complementary outputs with dead-time insertion;
- a sticky break latch.

It sits between the timer's register file and the pad muxing. Channel count and widths are generics rather than the fixed four-channel, 16-bit arrangement of the current timer.

---
 rtl/timx_pwm_gen.sv | 162 ++++++++++++++++
 tb/tb_timx_pwm_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/timx_pwm_gen.sv
// timx_pwm_gen: prescaled up/down/center PWM timer with preload, dead-time and break gating.
// Define TIMX_PWM_DEADTIME_EN to build the per-channel dead-time counters; otherwise dtg is ignored.
module timx_pwm_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PSC_W  = 16,
  parameter int DT_W   = 8
) (
  input  logic                    apb_clk,
  input  logic                    apb_rst,
  input  logic                    cnt_en,
  input  logic [1:0]              cms,
  input  logic [PSC_W-1:0]        psc,
  input  logic [CNT_W-1:0]        arr,
  input  logic [NUM_CH*CNT_W-1:0] ccr,
  input  logic [NUM_CH-1:0]       pol,
  input  logic [DT_W-1:0]         dtg,
  input  logic                    moe,
  input  logic                    bkin,
  input  logic                    brk_clr,
  input  logic                    ug,
  output logic [CNT_W-1:0]        cnt,
  output logic                    dir,
  output logic                    uev,
  output logic [NUM_CH-1:0]       cc_event,
  output logic [NUM_CH-1:0]       ch_out,
  output logic [NUM_CH-1:0]       chn_out,
  output logic [NUM_CH-1:0]       ch_out_en,
  output logic                    brk_flag
);
  logic [PSC_W-1:0]        psc_q, psc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, arr_sh_q, arr_sh_d;
  logic [NUM_CH*CNT_W-1:0] ccr_sh_q, ccr_sh_d;
  logic                    dir_q, dir_d, uev_q, uev_d, brk_q, brk_d;
  logic [NUM_CH-1:0]       cc_q, cc_d, oc_q, oc_d, dt_ch_q, dt_ch_d, dt_chn_q, dt_chn_d;
  logic [1:0]              mode;
  logic                    tick, ld, out_active;

  always_comb begin
    mode  = (cms == 2'b11) ? 2'b00 : cms;
    tick  = cnt_en & (psc_q == psc);
    psc_d = ug ? '0 : !cnt_en ? psc_q : tick ? '0 : psc_q + 1'b1;
    cnt_d = cnt_q;
    dir_d = dir_q;
    uev_d = 1'b0;
    if (ug) begin
      cnt_d = (mode == 2'b01) ? arr : '0;
      dir_d = 1'b0;
      uev_d = 1'b1;
    end else if (tick) begin
      if (mode == 2'b01) begin
        uev_d = (cnt_q == '0);
        cnt_d = uev_d ? arr_sh_q : cnt_q - 1'b1;
        dir_d = 1'b1;
      end else if (mode == 2'b10) begin
        if (arr_sh_q == '0) begin
          uev_d = 1'b1;
          cnt_d = '0;
          dir_d = 1'b0;
        end else if (!dir_q) begin
          uev_d = (cnt_q >= arr_sh_q - 1'b1);
          cnt_d = uev_d ? arr_sh_q : cnt_q + 1'b1;
          dir_d = uev_d;
        end else begin
          uev_d = (cnt_q <= CNT_W'(1));
          cnt_d = uev_d ? '0 : cnt_q - 1'b1;
          dir_d = ~uev_d;
        end
      end else begin
        uev_d = (cnt_q >= arr_sh_q);
        cnt_d = uev_d ? '0 : cnt_q + 1'b1;
        dir_d = 1'b0;
      end
    end
    // shadows follow the inputs only at period boundaries or on a software update
    ld       = ug | uev_d;
    arr_sh_d = ld ? arr : arr_sh_q;
    ccr_sh_d = ld ? ccr : ccr_sh_q;
    brk_d    = bkin | (brk_q & ~brk_clr);
    for (int k = 0; k < NUM_CH; k++) begin
      cc_d[k] = tick & ~ug & (cnt_d == ccr_sh_q[k*CNT_W +: CNT_W]);
      oc_d[k] = cnt_q < ccr_sh_q[k*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      psc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      uev_q    <= 1'b0;
      brk_q    <= 1'b0;
      cc_q     <= '0;
      oc_q     <= '0;
      arr_sh_q <= arr;
      ccr_sh_q <= ccr;
    end else begin
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      uev_q    <= uev_d;
      brk_q    <= brk_d;
      cc_q     <= cc_d;
      oc_q     <= oc_d;
      arr_sh_q <= arr_sh_d;
      ccr_sh_q <= ccr_sh_d;
    end
  end

`ifdef TIMX_PWM_DEADTIME_EN
  logic [NUM_CH-1:0]           ref_q;
  logic [NUM_CH-1:0][DT_W-1:0] dt_cnt_q, dt_cnt_d;

  // dt_cnt counts cycles since the last oc_ref edge, saturating; an output asserts once it reaches dtg
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      dt_cnt_d[k] = (oc_q[k] != ref_q[k]) ? '0 : (&dt_cnt_q[k]) ? dt_cnt_q[k] : dt_cnt_q[k] + 1'b1;
      dt_ch_d[k]  = oc_q[k] & (dt_cnt_d[k] >= dtg);
      dt_chn_d[k] = ~oc_q[k] & (dt_cnt_d[k] >= dtg);
    end
  end

  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      ref_q    <= '0;
      dt_cnt_q <= '0;
    end else begin
      ref_q    <= oc_q;
      dt_cnt_q <= dt_cnt_d;
    end
  end
`else
  logic unused_dtg;

  assign unused_dtg = ^dtg;

  always_comb begin
    dt_ch_d  = oc_q;
    dt_chn_d = ~oc_q;
  end
`endif

  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      dt_ch_q  <= '0;
      dt_chn_q <= '0;
    end else begin
      dt_ch_q  <= dt_ch_d;
      dt_chn_q <= dt_chn_d;
    end
  end

  assign out_active = moe & ~brk_q;
  assign ch_out     = out_active ? dt_ch_q ^ pol : pol;
  assign chn_out    = out_active ? dt_chn_q ^ pol : pol;
  assign ch_out_en  = {NUM_CH{out_active}};
  assign cnt        = cnt_q;
  assign dir        = dir_q;
  assign uev        = uev_q;
  assign cc_event   = cc_q;
  assign brk_flag   = brk_q;
endmodule

// File: tb/tb_timx_pwm_gen.sv
// tb_timx_pwm_gen: table-driven PWM statistics plus scoreboarded counter/preload/break sequences.
module tb_timx_pwm_gen;
  localparam int N = 4;
  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst, cnt_en, moe, bkin, brk_clr, ug;
  logic [1:0]      cms;
  logic [15:0]     psc;
  logic [W-1:0]    arr;
  logic [N*W-1:0]  ccr;
  logic [N-1:0]    pol;
  logic [7:0]      dtg;
  logic [W-1:0]    cnt;
  logic            dir, uev, brk_flag;
  logic [N-1:0]    cc_event, ch_out, chn_out, ch_out_en;

  always #5 clk = ~clk;

  timx_pwm_gen #(.NUM_CH(N), .CNT_W(W), .PSC_W(16), .DT_W(8)) dut (
    .apb_clk(clk), .apb_rst(rst), .cnt_en(cnt_en), .cms(cms), .psc(psc), .arr(arr),
    .ccr(ccr), .pol(pol), .dtg(dtg), .moe(moe), .bkin(bkin), .brk_clr(brk_clr), .ug(ug),
    .cnt(cnt), .dir(dir), .uev(uev), .cc_event(cc_event), .ch_out(ch_out),
    .chn_out(chn_out), .ch_out_en(ch_out_en), .brk_flag(brk_flag)
  );

  typedef struct {
    int cms, psc, arr, ccr, dtg, moe, pol, len;
    int e_uev, e_ch, e_chn, e_cc, e_en;
  } vec_t;

  typedef struct {
    int cnt, dir, uev;
  } obs_t;

  vec_t vecs[$];
  vec_t sb[$];
  obs_t oq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    obs_t e;
    e = oq.pop_front();
    chk({tag, "_cnt"}, int'(cnt), e.cnt);
    chk({tag, "_dir"}, int'(dir), e.dir);
    chk({tag, "_uev"}, int'(uev), e.uev);
  endtask

  task automatic push_obs(input int c, input int d, input int u);
    obs_t o;
    o.cnt = c;
    o.dir = d;
    o.uev = u;
    oq.push_back(o);
  endtask

  initial begin
    int n_uev, n_ch, n_chn, n_cc, n_en;
    int cseq[10], dseq[10], useq[10], pseq[16];
    vec_t e;
    cseq = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    dseq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    useq = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    pseq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 3, 4, 5, 0};
    //                    cms psc arr ccr dtg moe pol len  uev  ch chn  cc  en
    vecs.push_back(vec_t'{0,  0,  8,  7,  0,  1,  0,  90,  10, 70, 20, 10, 90});
    vecs.push_back(vec_t'{0,  1,  4,  2,  0,  1,  0,  100, 10, 40, 60, 10, 100});
    vecs.push_back(vec_t'{1,  0,  7,  3,  0,  1,  0,  80,  10, 30, 50, 10, 80});
    vecs.push_back(vec_t'{2,  0,  4,  2,  0,  1,  0,  80,  20, 30, 50, 20, 80});
    vecs.push_back(vec_t'{0,  0,  8,  0,  0,  1,  0,  90,  10, 0,  90, 10, 90});
    vecs.push_back(vec_t'{0,  0,  5,  9,  0,  1,  0,  60,  10, 60, 0,  0,  60});
    vecs.push_back(vec_t'{3,  0,  5,  3,  0,  1,  0,  60,  10, 30, 30, 10, 60});
    vecs.push_back(vec_t'{2,  2,  0,  1,  0,  1,  0,  90,  30, 90, 0,  0,  90});
    vecs.push_back(vec_t'{0,  0,  8,  4,  0,  0,  0,  90,  10, 0,  0,  10, 0});
    vecs.push_back(vec_t'{0,  0,  8,  7,  0,  1,  1,  90,  10, 20, 70, 10, 90});
`ifdef TIMX_PWM_DEADTIME_EN
    vecs.push_back(vec_t'{0,  0,  9,  4,  3,  1,  0,  100, 10, 10, 30, 10, 100});
    vecs.push_back(vec_t'{0,  0,  9,  2,  3,  1,  0,  100, 10, 0,  50, 10, 100});
`else
    vecs.push_back(vec_t'{0,  0,  9,  4,  3,  1,  0,  100, 10, 40, 60, 10, 100});
    vecs.push_back(vec_t'{0,  0,  9,  2,  3,  1,  0,  100, 10, 20, 80, 10, 100});
`endif

    rst = 1'b1; cnt_en = 1'b1; cms = 2'b00; psc = '0; arr = 16'd8; ccr = {N{16'd7}};
    pol = '0; dtg = '0; moe = 1'b0; bkin = 1'b0; brk_clr = 1'b0; ug = 1'b0;
    step();
    step();
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_uev", int'(uev), 0);
    chk("rst_cc", int'(cc_event), 0);
    chk("rst_brk", int'(brk_flag), 0);
    chk("rst_en", int'(ch_out_en), 0);
    chk("rst_ch", int'(ch_out), 0);
    chk("rst_chn", int'(chn_out), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cms = 2'(vecs[i].cms); psc = 16'(vecs[i].psc); arr = 16'(vecs[i].arr);
      ccr = {N{16'(vecs[i].ccr)}}; dtg = 8'(vecs[i].dtg); moe = vecs[i].moe[0];
      pol = {N{vecs[i].pol[0]}}; ug = 1'b1;
      sb.push_back(vecs[i]);
      step();
      ug = 1'b0;
      repeat (30) step();
      n_uev = 0; n_ch = 0; n_chn = 0; n_cc = 0; n_en = 0;
      for (int c = 0; c < vecs[i].len; c++) begin
        step();
        n_uev += int'(uev); n_ch += int'(ch_out[0]); n_chn += int'(chn_out[0]);
        n_cc += int'(cc_event[0]); n_en += int'(ch_out_en[0]);
      end
      e = sb.pop_front();
      chk($sformatf("v%0d_uev", i), n_uev, e.e_uev);
      chk($sformatf("v%0d_ch", i), n_ch, e.e_ch);
      chk($sformatf("v%0d_chn", i), n_chn, e.e_chn);
      chk($sformatf("v%0d_cc", i), n_cc, e.e_cc);
      chk($sformatf("v%0d_en", i), n_en, e.e_en);
    end

    cms = 2'b10; psc = '0; arr = 16'd4; dtg = '0; moe = 1'b1; pol = '0; ug = 1'b1;
    for (int i = 0; i < 10; i++) push_obs(cseq[i], dseq[i], useq[i]);
    for (int i = 0; i < 10; i++) begin
      step();
      ug = 1'b0;
      pop_chk($sformatf("ctr%0d", i));
    end

    cms = 2'b00; arr = 16'd8; ug = 1'b1;
    for (int i = 0; i < 16; i++) push_obs(pseq[i], 0, (i == 0 || i == 9 || i == 15) ? 1 : 0);
    for (int i = 0; i < 16; i++) begin
      step();
      ug = 1'b0;
      pop_chk($sformatf("pre%0d", i));
      if (i == 3) arr = 16'd5;
    end
    repeat (3) step();
    ug = 1'b1;
    push_obs(0, 0, 1);
    push_obs(1, 0, 0);
    step();
    ug = 1'b0;
    pop_chk("ug_mid");
    step();
    pop_chk("ug_after");

    arr = 16'd8; ccr = {N{16'd4}}; pol = 4'b0101; ug = 1'b1;
    step();
    ug = 1'b0;
    repeat (20) step();
    chk("brk_pre_en", int'(ch_out_en), 15);
    bkin = 1'b1;
    step();
    chk("brk_flag_set", int'(brk_flag), 1);
    chk("brk_en_off", int'(ch_out_en), 0);
    chk("brk_ch_idle", int'(ch_out), 5);
    chk("brk_chn_idle", int'(chn_out), 5);
    brk_clr = 1'b1;
    step();
    chk("brk_clr_blocked", int'(brk_flag), 1);
    bkin = 1'b0;
    step();
    brk_clr = 1'b0;
    chk("brk_cleared", int'(brk_flag), 0);
    chk("brk_en_back", int'(ch_out_en), 15);
    repeat (12) step();
`ifndef TIMX_PWM_DEADTIME_EN
    chk("brk_comp", int'(ch_out[0] ^ chn_out[0]), 1);
`endif

    bkin = 1'b1;
    step();
    bkin = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("mrst_cnt", int'(cnt), 0);
    chk("mrst_brk", int'(brk_flag), 0);
    chk("mrst_dir", int'(dir), 0);
    chk("mrst_ch", int'(ch_out), 5);
    chk("mrst_chn", int'(chn_out), 5);
    rst = 1'b0;
    step();
    chk("mrst_cnt1", int'(cnt), 1);
    step();
    chk("mrst_cnt2", int'(cnt), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
